// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, one-hot T-states and
// control-word bit positions so the datapath, sequencer and benches agree.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   localparam int CW_W        = 15;
   localparam int CW_PC_OUT   = 0;
   localparam int CW_PC_INC   = 1;
   localparam int CW_JMP      = 2;
   localparam int CW_MAR_IN   = 3;
   localparam int CW_RAM_OUT  = 4;
   localparam int CW_RAM_IN   = 5;
   localparam int CW_IR_IN    = 6;
   localparam int CW_IR_OUT   = 7;
   localparam int CW_A_IN     = 8;
   localparam int CW_A_OUT    = 9;
   localparam int CW_B_IN     = 10;
   localparam int CW_ALU_OUT  = 11;
   localparam int CW_ALU_SUB  = 12;
   localparam int CW_FLAGS_IN = 13;
   localparam int CW_OUT_IN   = 14;

   typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR opcode and flags in, control strobes out.
interface control_sequencer_if;
   logic [3:0] opcode;
   logic       flag_zero, flag_carry;
   logic       pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
   logic       halt;
   logic [5:0] t_state;

   modport master (
      input  opcode, flag_zero, flag_carry,
      output pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out,
      output a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
      output halt, t_state
   );

   modport slave (
      output opcode, flag_zero, flag_carry,
      input  pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out,
      input  a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
      input  halt, t_state
   );
endinterface

// File: rtl/ring_counter.sv
// Six-step one-hot T-state generator; clear and restart force T1, freeze holds.
module ring_counter
   import cpu_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic       restart,
   input  logic       freeze,
   output logic [5:0] step
);

   always_ff @(posedge clock) begin
      if (clear)
         step <= T1;
      else if (freeze)
         step <= step;
      else if (restart)
         step <= T1;
      else
         step <= {step[4:0], step[5]};
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: decodes (T-state, opcode, flags) into one control
// word per clock and owns the halt latch; stepping lives in ring_counter.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter bit EARLY_END = 1'b1
) (
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   logic [5:0] step;
   ctrl_word_t cw, cw_q;
   logic       last, hlt_go, halted, restart;

   assign restart = EARLY_END && last;

   ring_counter u_ring (
      .clock   (clock),
      .clear   (clear),
      .restart (restart),
      .freeze  (halted),
      .step    (step)
   );

   always_comb begin
      cw     = '0;
      last   = 1'b0;
      hlt_go = 1'b0;
      case (step)
         T1: begin cw[CW_PC_OUT] = 1'b1; cw[CW_MAR_IN] = 1'b1; end
         T2: cw[CW_PC_INC] = 1'b1;
         T3: begin cw[CW_RAM_OUT] = 1'b1; cw[CW_IR_IN] = 1'b1; end
         T4: begin
            case (bus.opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw[CW_IR_OUT] = 1'b1; cw[CW_MAR_IN] = 1'b1;
               end
               OP_LDI: begin cw[CW_IR_OUT] = 1'b1; cw[CW_A_IN] = 1'b1; last = 1'b1; end
               OP_JMP: begin cw[CW_IR_OUT] = 1'b1; cw[CW_JMP] = 1'b1; last = 1'b1; end
               // Conditional jumps still end here when the branch is not taken.
               OP_JC: begin
                  cw[CW_IR_OUT] = bus.flag_carry; cw[CW_JMP] = bus.flag_carry; last = 1'b1;
               end
               OP_JZ: begin
                  cw[CW_IR_OUT] = bus.flag_zero; cw[CW_JMP] = bus.flag_zero; last = 1'b1;
               end
               OP_OUT: begin cw[CW_A_OUT] = 1'b1; cw[CW_OUT_IN] = 1'b1; last = 1'b1; end
               OP_HLT: begin hlt_go = 1'b1; last = 1'b1; end
               default: last = 1'b1;
            endcase
         end
         T5: begin
            case (bus.opcode)
               OP_LDA: begin cw[CW_RAM_OUT] = 1'b1; cw[CW_A_IN] = 1'b1; last = 1'b1; end
               OP_ADD, OP_SUB: begin cw[CW_RAM_OUT] = 1'b1; cw[CW_B_IN] = 1'b1; end
               OP_STA: begin cw[CW_A_OUT] = 1'b1; cw[CW_RAM_IN] = 1'b1; last = 1'b1; end
               default: ;
            endcase
         end
         T6: begin
            if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
               cw[CW_ALU_OUT]  = 1'b1;
               cw[CW_A_IN]     = 1'b1;
               cw[CW_FLAGS_IN] = 1'b1;
               cw[CW_ALU_SUB]  = (bus.opcode == OP_SUB);
               last            = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear)
         halted <= 1'b0;
      else if (hlt_go)
         halted <= 1'b1;
   end

   // Clear and halt both mask the decode so no partial strobes escape.
   assign cw_q = (clear || halted) ? '0 : cw;

   assign bus.pc_out   = cw_q[CW_PC_OUT];
   assign bus.pc_inc   = cw_q[CW_PC_INC];
   assign bus.jmp      = cw_q[CW_JMP];
   assign bus.mar_in   = cw_q[CW_MAR_IN];
   assign bus.ram_out  = cw_q[CW_RAM_OUT];
   assign bus.ram_in   = cw_q[CW_RAM_IN];
   assign bus.ir_in    = cw_q[CW_IR_IN];
   assign bus.ir_out   = cw_q[CW_IR_OUT];
   assign bus.a_in     = cw_q[CW_A_IN];
   assign bus.a_out    = cw_q[CW_A_OUT];
   assign bus.b_in     = cw_q[CW_B_IN];
   assign bus.alu_out  = cw_q[CW_ALU_OUT];
   assign bus.alu_sub  = cw_q[CW_ALU_SUB];
   assign bus.flags_in = cw_q[CW_FLAGS_IN];
   assign bus.out_in   = cw_q[CW_OUT_IN];
   assign bus.halt     = halted && !clear;
   assign bus.t_state  = clear ? T1 : (halted ? 6'b000000 : step);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: one DUT per EARLY_END setting; expected per-cycle control
// words are queued as stimulus is driven and compared on the falling edge.
module tb_control_sequencer;
   import cpu_pkg::*;

   typedef struct {
      int         sel;
      ctrl_word_t cw;
      logic [5:0] t;
      logic       h;
      string      tag;
   } exp_t;

   localparam ctrl_word_t ONE  = 1;
   localparam ctrl_word_t NONE = '0;
   localparam ctrl_word_t F1   = (ONE << CW_PC_OUT) | (ONE << CW_MAR_IN);
   localparam ctrl_word_t F2   = (ONE << CW_PC_INC);
   localparam ctrl_word_t F3   = (ONE << CW_RAM_OUT) | (ONE << CW_IR_IN);
   localparam ctrl_word_t ADR  = (ONE << CW_IR_OUT) | (ONE << CW_MAR_IN);
   localparam ctrl_word_t LDB  = (ONE << CW_RAM_OUT) | (ONE << CW_B_IN);
   localparam ctrl_word_t ACC  = (ONE << CW_ALU_OUT) | (ONE << CW_A_IN) | (ONE << CW_FLAGS_IN);
   localparam ctrl_word_t SUBW = ACC | (ONE << CW_ALU_SUB);
   localparam ctrl_word_t JMPW = (ONE << CW_IR_OUT) | (ONE << CW_JMP);
   localparam ctrl_word_t LDA5 = (ONE << CW_RAM_OUT) | (ONE << CW_A_IN);
   localparam ctrl_word_t STA5 = (ONE << CW_A_OUT) | (ONE << CW_RAM_IN);
   localparam ctrl_word_t OUTW = (ONE << CW_A_OUT) | (ONE << CW_OUT_IN);
   localparam ctrl_word_t LDIW = (ONE << CW_IR_OUT) | (ONE << CW_A_IN);

   logic       clock = 1'b0;
   logic [1:0] clr = 2'b11;
   logic [3:0] op = OP_NOP;
   logic       fz = 1'b0, fc = 1'b0;
   ctrl_word_t obs_cw [2];
   logic [5:0] obs_t [2];
   logic       obs_h [2];
   exp_t       sbq [$];
   int         checks = 0, errors = 0;

   always #5 clock = ~clock;

   control_sequencer_if bus [2] ();

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_dut
         ctrl_word_t ocw;
         assign bus[g].opcode     = op;
         assign bus[g].flag_zero  = fz;
         assign bus[g].flag_carry = fc;
         control_sequencer #(.EARLY_END(g == 1)) u_dut (
            .clock (clock),
            .clear (clr[g]),
            .bus   (bus[g])
         );
         always_comb begin
            ocw              = '0;
            ocw[CW_PC_OUT]   = bus[g].pc_out;
            ocw[CW_PC_INC]   = bus[g].pc_inc;
            ocw[CW_JMP]      = bus[g].jmp;
            ocw[CW_MAR_IN]   = bus[g].mar_in;
            ocw[CW_RAM_OUT]  = bus[g].ram_out;
            ocw[CW_RAM_IN]   = bus[g].ram_in;
            ocw[CW_IR_IN]    = bus[g].ir_in;
            ocw[CW_IR_OUT]   = bus[g].ir_out;
            ocw[CW_A_IN]     = bus[g].a_in;
            ocw[CW_A_OUT]    = bus[g].a_out;
            ocw[CW_B_IN]     = bus[g].b_in;
            ocw[CW_ALU_OUT]  = bus[g].alu_out;
            ocw[CW_ALU_SUB]  = bus[g].alu_sub;
            ocw[CW_FLAGS_IN] = bus[g].flags_in;
            ocw[CW_OUT_IN]   = bus[g].out_in;
         end
         assign obs_cw[g] = ocw;
         assign obs_t[g]  = bus[g].t_state;
         assign obs_h[g]  = bus[g].halt;
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         chk("inc_jmp_excl", 32'(obs_cw[i][CW_PC_INC] & obs_cw[i][CW_JMP]), 32'd0);
         chk("one_driver", 32'($countones({obs_cw[i][CW_PC_OUT], obs_cw[i][CW_RAM_OUT],
             obs_cw[i][CW_IR_OUT], obs_cw[i][CW_A_OUT], obs_cw[i][CW_ALU_OUT]}) <= 1), 32'd1);
      end
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({e.tag, "_cw"}, 32'(obs_cw[e.sel]), 32'(e.cw));
         chk({e.tag, "_t"},  32'(obs_t[e.sel]),  32'(e.t));
         chk({e.tag, "_h"},  32'(obs_h[e.sel]),  32'(e.h));
      end
   end

   // Drive one cycle on DUT s (the other DUT is held in clear) and queue its expectation.
   task automatic cyc(input int s, input logic [3:0] o, input logic z, input logic c,
                      input logic cl, input ctrl_word_t ecw, input logic [5:0] et,
                      input logic eh, input string tag);
      exp_t e;
      @(posedge clock); #1;
      op = o; fz = z; fc = c;
      clr[s] = cl; clr[1-s] = 1'b1;
      e.sel = s; e.cw = ecw; e.t = et; e.h = eh; e.tag = tag;
      sbq.push_back(e);
   endtask

   task automatic ex(input int s, input logic [3:0] o, input logic z, input logic c,
                     input ctrl_word_t ecw, input logic [5:0] et, input string tag);
      cyc(s, o, z, c, 1'b0, ecw, et, 1'b0, tag);
   endtask

   task automatic fetch(input int s, input logic [3:0] o, input logic z, input logic c);
      ex(s, o, z, c, F1, T1, "fetch_t1");
      ex(s, o, z, c, F2, T2, "fetch_t2");
      ex(s, o, z, c, F3, T3, "fetch_t3");
   endtask

   initial begin
      // EARLY_END = 1
      cyc(1, OP_NOP, 0, 0, 1'b1, NONE, T1, 1'b0, "reset");
      fetch(1, OP_NOP, 0, 0);  ex(1, OP_NOP, 0, 0, NONE, T4, "nop_t4");
      fetch(1, OP_ADD, 0, 0);  ex(1, OP_ADD, 0, 0, ADR, T4, "add_t4");
      ex(1, OP_ADD, 0, 0, LDB, T5, "add_t5");  ex(1, OP_ADD, 0, 0, ACC, T6, "add_t6");
      fetch(1, OP_SUB, 0, 0);  ex(1, OP_SUB, 0, 0, ADR, T4, "sub_t4");
      ex(1, OP_SUB, 0, 0, LDB, T5, "sub_t5");  ex(1, OP_SUB, 0, 0, SUBW, T6, "sub_t6");
      fetch(1, OP_JC, 0, 0);   ex(1, OP_JC, 0, 0, NONE, T4, "jc_nc_t4");
      fetch(1, OP_JC, 0, 0);   ex(1, OP_JC, 0, 1, JMPW, T4, "jc_c_t4");
      fetch(1, OP_JZ, 0, 1);   ex(1, OP_JZ, 0, 1, NONE, T4, "jz_nz_t4");
      fetch(1, OP_JZ, 1, 0);   ex(1, OP_JZ, 1, 0, JMPW, T4, "jz_z_t4");
      fetch(1, OP_JMP, 0, 0);  ex(1, OP_JMP, 0, 0, JMPW, T4, "jmp_t4");
      fetch(1, OP_LDA, 0, 0);  ex(1, OP_LDA, 0, 0, ADR, T4, "lda_t4");
      ex(1, OP_LDA, 0, 0, LDA5, T5, "lda_t5");
      fetch(1, OP_STA, 0, 0);  ex(1, OP_STA, 0, 0, ADR, T4, "sta_t4");
      ex(1, OP_STA, 0, 0, STA5, T5, "sta_t5");
      fetch(1, OP_OUT, 0, 0);  ex(1, OP_OUT, 0, 0, OUTW, T4, "out_t4");
      fetch(1, OP_LDI, 0, 0);  ex(1, OP_LDI, 0, 0, LDIW, T4, "ldi_t4");
      fetch(1, 4'hA, 1, 1);    ex(1, 4'hA, 1, 1, NONE, T4, "undef_t4");
      // clear lands in T5 of LDA: that cycle must be silent
      fetch(1, OP_LDA, 0, 0);  ex(1, OP_LDA, 0, 0, ADR, T4, "lda2_t4");
      cyc(1, OP_LDA, 0, 0, 1'b1, NONE, T1, 1'b0, "abort_t5");
      fetch(1, OP_HLT, 0, 0);  ex(1, OP_HLT, 0, 0, NONE, T4, "hlt_t4");
      for (int i = 0; i < 20; i++) cyc(1, OP_HLT, 1, 1, 1'b0, NONE, 6'b0, 1'b1, "halted");
      cyc(1, OP_HLT, 0, 0, 1'b1, NONE, T1, 1'b0, "halt_clear");
      ex(1, OP_NOP, 0, 0, F1, T1, "post_halt_t1");

      // EARLY_END = 0
      cyc(0, OP_LDI, 0, 0, 1'b1, NONE, T1, 1'b0, "reset0");
      fetch(0, OP_LDI, 0, 0);  ex(0, OP_LDI, 0, 0, LDIW, T4, "ldi0_t4");
      ex(0, OP_LDI, 0, 0, NONE, T5, "ldi0_t5");  ex(0, OP_LDI, 0, 0, NONE, T6, "ldi0_t6");
      fetch(0, OP_LDA, 0, 0);  ex(0, OP_LDA, 0, 0, ADR, T4, "lda0_t4");
      ex(0, OP_LDA, 0, 0, LDA5, T5, "lda0_t5");  ex(0, OP_LDA, 0, 0, NONE, T6, "lda0_t6");
      fetch(0, OP_HLT, 0, 0);  ex(0, OP_HLT, 0, 0, NONE, T4, "hlt0_t4");
      for (int i = 0; i < 4; i++) cyc(0, OP_HLT, 0, 0, 1'b0, NONE, 6'b0, 1'b1, "halted0");
      cyc(0, OP_NOP, 0, 0, 1'b1, NONE, T1, 1'b0, "halt0_clear");
      ex(0, OP_NOP, 0, 0, F1, T1, "post_halt0_t1");

      @(negedge clock); #1;
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 4-bit-address accumulator CPU.
- Sits directly upstream of the program counter, MAR, RAM, IR, A/B registers, ALU and output register; drives their control strobes (pc_inc, jmp, pc_out, mar_in, ...).
- Consumes the IR opcode and the ALU flags.
- Steps a T-state sequencer (fetch T1–T3, execute T4–T6) and decodes each opcode/T-state pair into one control word per clock.

Parameters:
- EARLY_END, 1, when 1 the sequencer returns to T1 right after an instruction's last active step; when 0 it always runs T1–T6.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous active-high reset.
- opcode  in  4  upper nibble of IR; valid from T4 onward.
- flag_zero  in  1  registered zero flag from flags register.
- flag_carry  in  1  registered carry flag from flags register.
- pc_out, pc_inc, jmp  out  1 each  program counter strobes.
- mar_in  out  1  MAR load.
- ram_out, ram_in  out  1 each  RAM drive / write.
- ir_in, ir_out  out  1 each  IR load / drive operand nibble.
- a_in, a_out, b_in  out  1 each  accumulator and B register strobes.
- alu_out, alu_sub  out  1 each  ALU drive / subtract select.
- flags_in  out  1  flags register load.
- out_in  out  1  output register load.
- halt  out  1  high while halted.
- t_state  out  6  one-hot current step, bit0 = T1.

Behaviour:
- Reset: synchronous. On a posedge with clear=1, state <= T1 and halted <= 0. While clear=1, every control output is forced 0 and t_state = 6'b000001. Reset mid-instruction aborts it; no partial strobes follow.
- Control outputs are combinational decode of (state, opcode, flags). No output latency; strobes are valid for the whole cycle and consumed at the next posedge.
- Fetch, identical for every opcode:
  - T1: pc_out, mar_in.
  - T2: pc_inc.
  - T3: ram_out, ir_in.
- Execute (T4–T6). Unlisted steps drive all outputs 0. "end" marks the last active step.
  - 0000 NOP: T4 end (nothing driven).
  - 0001 LDA: T4 ir_out+mar_in; T5 ram_out+a_in end.
  - 0010 ADD: T4 ir_out+mar_in; T5 ram_out+b_in; T6 alu_out+a_in+flags_in end.
  - 0011 SUB: as ADD, plus alu_sub in T6.
  - 0100 STA: T4 ir_out+mar_in; T5 a_out+ram_in end.
  - 0101 LDI: T4 ir_out+a_in end.
  - 0110 JMP: T4 ir_out+jmp end.
  - 0111 JC: T4 ir_out+jmp only if flag_carry=1; end either way.
  - 1000 JZ: T4 ir_out+jmp only if flag_zero=1; end either way.
  - 1110 OUT: T4 a_out+out_in end.
  - 1111 HLT: T4 enter HALT.
  - Undefined opcodes (1001–1101) execute as NOP.
- Step advance:
  - EARLY_END=1: after an end step, next state is T1.
  - EARLY_END=0: states T4..T6 all run, then T1.
  - T6 always wraps to T1.
- HALT:
  - Entered on the posedge ending T4 of HLT. halt=1 from the next cycle until clear.
  - In HALT, all other outputs are 0 and t_state is 0 (no step bit set).
  - Only clear exits HALT.
- Invariants:
  - pc_inc and jmp never assert in the same cycle.
  - At most one bus driver asserts per cycle: pc_out, ram_out, ir_out, a_out, alu_out.
- Flags are sampled combinationally in T4. A flag change in that same cycle affects the decision.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_NOP … OP_HLT);
  - T-state one-hot constants T1..T6;
  - control-word bit-index constants, so datapath blocks and benches agree on ordering.
- Sub-module ring_counter:
  - 6-bit one-hot step generator with synchronous clear, restart (force T1) and freeze (halt) inputs.
  - control_sequencer instantiates it and holds only decode and halt logic.

Test Plan:
- Release clear, opcode=0000, EARLY_END=1 -> T1 pc_out=mar_in=1; T2 pc_inc=1; T3 ram_out=ir_in=1; T4 all 0; next cycle t_state=000001.
- opcode=0010 (ADD), EARLY_END=1 -> T4 ir_out+mar_in; T5 ram_out+b_in; T6 alu_out+a_in+flags_in; then T1. Repeat with 0011 -> alu_sub=1 in T6 only.
- opcode=0111 (JC): flag_carry=0 -> T4 jmp=0, back to T1; flag_carry=1 -> T4 ir_out=jmp=1. Repeat for 1000 with flag_zero.
- opcode=1111 -> halt=1 from the cycle after T4; hold 20 cycles -> all strobes 0, t_state=0; pulse clear -> halt=0, t_state=000001 after release.
- EARLY_END=0, opcode=0101 (LDI) -> T4 ir_out+a_in; T5, T6 all 0; then T1 (six-cycle instruction).
- Assert clear during T5 of LDA -> all outputs 0 that cycle, t_state=000001 after release. Assertion check across all tests: never pc_inc&jmp; never more than one bus driver high.
